ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage.
- Consumes the operand and control fields produced by the ID/EX pipeline register and owns the architectural HI/LO registers.
- Raises a stall request while an operation is in flight so that IF/ID/ID_EX hold.
- Reports completion with a one-cycle pulse.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): operand, HI and LO width.
- CNT_W, $clog2(DATA_WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high (asserted when rst == `RST_VALID).
- i_start  in  1  request from the EX-stage control decode (valid op this cycle).
- i_op  in  3  operation: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; others are NOP.
- i_data1  in  DATA_WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source).
- i_data2  in  DATA_WIDTH  rt operand (multiplier/divisor).
- i_flush  in  1  kill the in-flight operation (branch/exception flush).
- o_busy  out  1  stall request to the hazard unit.
- o_done  out  1  one-cycle completion pulse.
- o_div_zero  out  1  pulses with o_done when the divisor was 0.
- o_hi  out  DATA_WIDTH  HI register.
- o_lo  out  DATA_WIDTH  LO register.

Behaviour:
- Reset: state IDLE; o_hi, o_lo, o_done, o_div_zero, counter and internal accumulators all '0; o_busy 0.
- Reset has priority over everything, including mid-operation; the operation is abandoned.
- FSM states: IDLE, CALC, FIXUP.
- IDLE + i_start + MTHI/MTLO: HI or LO <= i_data1 at the next edge. Single cycle; o_busy stays 0; no o_done.
- IDLE + i_start + mul/div (accept cycle T):
  - Latch operand magnitudes, sign flags and op; counter <= DATA_WIDTH.
  - o_busy is combinationally 1 in cycle T.
  - Signed ops: magnitude = two's-complement negate when MSB=1. Unsigned ops: sign flags 0.
- CALC, one bit per cycle, counter decrements:
  - Multiply: radix-2 shift-add into a 2*DATA_WIDTH product.
  - Divide: restoring division producing quotient and remainder.
  - Leaves CALC when the counter reaches 0 (cycles T+1..T+32 for 32-bit).
- FIXUP (T+33): apply signs.
  - Product negated if s1^s2.
  - Quotient negated if s1^s2.
  - Remainder takes the sign of the dividend.
  - HI <= product[63:32] or remainder; LO <= product[31:0] or quotient. Written at the end of FIXUP.
- o_done (registered) is 1 in cycle T+34, state IDLE, with the new HI/LO visible.
- o_busy = 1 from T through T+33, 0 at T+34. Total stall is 34 cycles.
- Divide by zero (DIV/DIVU with i_data2 == 0):
  - Skip CALC; go directly to FIXUP at T+1.
  - HI <= i_data1 unmodified; LO <= all ones.
  - o_done and o_div_zero both 1 at T+2.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of magnitude arithmetic; no special case.
- i_start while not IDLE: ignored (the pipeline is stalled and holds the instruction).
- i_flush:
  - Any state: next state IDLE; HI/LO unchanged; no o_done.
  - Flush beats a simultaneous i_start, including MTHI/MTLO.
  - o_busy follows the registered state after the flush, plus the combinational accept term.
- o_hi/o_lo drive registers directly. Consumers (MFHI/MFLO) must wait until o_busy = 0.

Decomposition:
- muldiv_pkg holds:
  - op encoding localparams/enum (OP_NOP..OP_MTLO);
  - state enum (IDLE, CALC, FIXUP);
  - MULDIV_LAT = DATA_WIDTH+2.
- DATA_WIDTH stays in define.sv.
- One sub-module, muldiv_datapath: shift-add/restoring step logic plus sign fixup.
- FSM, counter and HI/LO registers stay in ex_muldiv.

Test Plan:
- Reset mid-CALC (MULT issued, rst at T+10) -> next cycle o_hi=o_lo=0, o_busy=0, no o_done.
- MULT 0xFFFFFFFD × 0x00000005 -> o_done at T+34; HI=0xFFFFFFFF, LO=0xFFFFFFF1; o_busy high exactly T..T+33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 -> o_done and o_div_zero at T+2; HI=5, LO=0xFFFFFFFF.
- MTHI 0x12345678 in IDLE -> o_hi=0x12345678 next cycle, o_busy never 1.
- Issue DIVU, then i_flush at T+10 -> o_busy 0 at T+11; HI/LO keep their prior values; no o_done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encoding, FSM states and latency for the EX-stage multiply/divide unit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RST_VALID
`define RST_VALID 1'b1
`endif

package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  // Accept cycle to the o_done cycle, inclusive of the accept cycle.
  localparam int MULDIV_LAT = `DATA_WIDTH + 2;

endpackage

// File: rtl/define.sv
// Codebase-wide width and reset-polarity macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RST_VALID
`define RST_VALID 1'b1
`endif

// File: rtl/ex_muldiv_datapath.sv
// One shift-add / restoring-division step plus the final sign fixup.
module ex_muldiv_datapath #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  is_div,
  input  logic                  div_zero,
  input  logic                  s1,
  input  logic                  s2,
  input  logic [DATA_WIDTH-1:0] acc_hi,
  input  logic [DATA_WIDTH-1:0] acc_lo,
  input  logic [DATA_WIDTH-1:0] mag,
  output logic [DATA_WIDTH-1:0] step_hi,
  output logic [DATA_WIDTH-1:0] step_lo,
  output logic [DATA_WIDTH-1:0] fix_hi,
  output logic [DATA_WIDTH-1:0] fix_lo
);

  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_shift;
  logic [DATA_WIDTH-1:0]   div_sub;
  logic                    div_ge;
  logic [2*DATA_WIDTH-1:0] prod;

  // Multiply: acc_lo holds the unconsumed multiplier bits, acc_hi the running partial sum.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag};
    div_sub   = div_shift[DATA_WIDTH-1:0] - mag;
    if (is_div) begin
      step_hi = div_ge ? div_sub : div_shift[DATA_WIDTH-1:0];
      step_lo = {acc_lo[DATA_WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (!is_div) begin
      {fix_hi, fix_lo} = (s1 ^ s2) ? -prod : prod;
    end else if (div_zero) begin
      // acc_hi carries the dividend magnitude; re-applying its sign restores the raw value.
      fix_hi = s1 ? -acc_hi : acc_hi;
      fix_lo = '1;
    end else begin
      fix_hi = s1 ? -acc_hi : acc_hi;
      fix_lo = (s1 ^ s2) ? -acc_lo : acc_lo;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning HI/LO; stalls the front end while busy.
// Handshake: i_start is honoured only in IDLE without i_flush; o_done pulses one cycle with HI/LO updated.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_div_zero,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] acc_hi, acc_lo, mag;
  logic                  s1, s2, is_div, dz;

  op_e                   op;
  logic                  op_md, op_signed, op_div, op_zero, accept;
  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic [DATA_WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;

  always_comb begin
    op        = op_e'(i_op);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_md     = op_div || (op == OP_MULT) || (op == OP_MULTU);
    op_zero   = op_div && (i_data2 == '0);
    mag1      = (op_signed && i_data1[DATA_WIDTH-1]) ? -i_data1 : i_data1;
    mag2      = (op_signed && i_data2[DATA_WIDTH-1]) ? -i_data2 : i_data2;
    accept    = (state == IDLE) && i_start && !i_flush && op_md;
    o_busy    = (state != IDLE) || accept;
  end

  ex_muldiv_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_datapath (
    .is_div   (is_div),
    .div_zero (dz),
    .s1       (s1),
    .s2       (s2),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .mag      (mag),
    .step_hi  (step_hi),
    .step_lo  (step_lo),
    .fix_hi   (fix_hi),
    .fix_lo   (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (rst == `RST_VALID) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      mag        <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      is_div     <= 1'b0;
      dz         <= 1'b0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      o_hi       <= '0;
      o_lo       <= '0;
    end else begin
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      if (i_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_start && op == OP_MTHI) o_hi <= i_data1;
            if (i_start && op == OP_MTLO) o_lo <= i_data1;
            if (accept) begin
              s1     <= op_signed && i_data1[DATA_WIDTH-1];
              s2     <= op_signed && i_data2[DATA_WIDTH-1];
              is_div <= op_div;
              dz     <= op_zero;
              cnt    <= CNT_W'(DATA_WIDTH);
              acc_hi <= op_zero ? mag1 : '0;
              acc_lo <= op_div ? mag1 : mag2;
              mag    <= op_div ? mag2 : mag1;
              state  <= op_zero ? FIXUP : CALC;
            end
          end
          CALC: begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIXUP;
          end
          FIXUP: begin
            o_hi       <= fix_hi;
            o_lo       <= fix_lo;
            o_done     <= 1'b1;
            o_div_zero <= dz;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed bench for ex_muldiv against an arithmetic HI/LO reference model.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [2:0]   i_op = 3'd0;
  logic [W-1:0] i_data1 = '0;
  logic [W-1:0] i_data2 = '0;
  logic         i_flush = 1'b0;
  logic         o_busy, o_done, o_div_zero;
  logic [W-1:0] o_hi, o_lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_data1    (i_data1),
    .i_data2    (i_data2),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div_zero (o_div_zero),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      3'd1: res = 64'(sa * sb);
      3'd2: res = ua * ub;
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: res = {exp_hi, exp_lo};
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, then watch every following cycle until the expected done (or a kill).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_k, input int rst_k, input int poke_k);
    logic        is_md, dz, killed;
    logic [63:0] res;
    int          lat;
    is_md  = (op >= 3'd1) && (op <= 3'd4);
    dz     = (op == 3'd3 || op == 3'd4) && (b == '0);
    lat    = dz ? 2 : W + 2;
    killed = 1'b0;
    res    = model(op, a, b);
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_data1 = a; i_data2 = b;
    #1;
    check_eq("busy_at_accept", o_busy, is_md);
    if (!is_md) begin
      @(negedge clk);
      i_start = 1'b0;
      if (op == 3'd5) exp_hi = a;
      if (op == 3'd6) exp_lo = a;
      #1;
      check_eq("mt_busy", o_busy, 0);
      check_eq("mt_done", o_done, 0);
      check_eq("mt_hi", o_hi, exp_hi);
      check_eq("mt_lo", o_lo, exp_lo);
      return;
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      i_start = (k == poke_k); i_op = 3'd5; i_data1 = ~a;
      i_flush = 1'b0; rst = 1'b0;
      #1;
      if (killed) begin
        check_eq("kill_busy", o_busy, 0);
        check_eq("kill_done", o_done, 0);
        check_eq("kill_hi", o_hi, exp_hi);
        check_eq("kill_lo", o_lo, exp_lo);
        break;
      end
      check_eq("busy", o_busy, k < lat);
      check_eq("done", o_done, k == lat);
      check_eq("div_zero", o_div_zero, (k == lat) && dz);
      if (k == lat) begin
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        check_eq("hi", o_hi, exp_hi);
        check_eq("lo", o_lo, exp_lo);
      end
      if (k == flush_k) begin i_flush = 1'b1; killed = 1'b1; end
      if (k == rst_k) begin rst = 1'b1; killed = 1'b1; exp_hi = '0; exp_lo = '0; end
    end
    i_start = 1'b0; i_flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_hi", o_hi, 0);
    check_eq("rst_lo", o_lo, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_divz", o_div_zero, 0);
    rst = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFD, 32'h0000_0005, -1, -1, 5);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1, -1);
    run_op(3'd4, 32'd100, 32'd7, -1, -1, -1);
    run_op(3'd4, 32'd5, 32'd0, -1, -1, -1);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd0, -1, -1, -1);
    run_op(3'd5, 32'h1234_5678, 32'd0, -1, -1, -1);
    run_op(3'd6, 32'hCAFE_F00D, 32'd0, -1, -1, -1);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd3, 10, -1, -1);
    run_op(3'd1, 32'h0000_1234, 32'h0000_5678, -1, 10, -1);

    // Flush in the same cycle as a start must win, for both MTHI and a multiply.
    @(negedge clk);
    i_start = 1'b1; i_op = 3'd5; i_data1 = 32'hDEAD_BEEF; i_flush = 1'b1;
    #1;
    check_eq("flush_mthi_busy", o_busy, 0);
    @(negedge clk);
    i_op = 3'd1; i_data2 = 32'd7;
    #1;
    check_eq("flush_mthi_hi", o_hi, exp_hi);
    check_eq("flush_mult_busy", o_busy, 0);
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    #1;
    check_eq("flush_mult_idle", o_busy, 0);
    check_eq("flush_mult_done", o_done, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, -1, -1, ($urandom_range(0, 3) == 0) ? 7 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
